// File: rtl/cpu_pkg.sv
// Shared CPU definitions: R-format opcode/funct constants, ALU operation
// encodings, and the decode helper used by the decode stage.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // Same encodings are consumed by the execute stage's ALU.
    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    typedef struct packed {
        logic    legal;
        alu_op_t op;
    } decode_t;

    function automatic decode_t decode_r_format(input logic [5:0] opcode,
                                                input logic [5:0] funct);
        decode_t d;
        d.legal = (opcode == OP_RTYPE);
        d.op    = ALU_AND;
        case (funct)
            FUNCT_AND: d.op = ALU_AND;
            FUNCT_OR:  d.op = ALU_OR;
            FUNCT_ADD: d.op = ALU_ADD;
            FUNCT_SUB: d.op = ALU_SUB;
            FUNCT_SLT: d.op = ALU_SLT;
            default:   d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file: two combinational read ports, one synchronous
// write port, hardwired zero register and asynchronous clear.
module register_file #(
    parameter int REG_COUNT  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset_input,
    input  logic [ADDR_WIDTH-1:0] read_addr_a,
    output logic [DATA_WIDTH-1:0] read_data_a,
    input  logic [ADDR_WIDTH-1:0] read_addr_b,
    output logic [DATA_WIDTH-1:0] read_data_b,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data
);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    always_ff @(posedge clk or negedge reset_input) begin
        if (!reset_input) begin
            // NOTE: the array is cleared on reset because software relies on
            // all registers reading zero after reset; this forces flops, not RAM.
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable && write_addr != '0) begin
            // NOTE: non-blocking so a same-edge read elsewhere sees the old value.
            regs[write_addr] <= write_data;
        end
    end

    assign read_data_a = (read_addr_a == '0) ? '0 : regs[read_addr_a];
    assign read_data_b = (read_addr_b == '0) ? '0 : regs[read_addr_b];

endmodule

// File: rtl/r_format_decode.sv
// R-format decode/register-read stage: decodes funct to an ALU operation,
// reads operands with write-back bypass, and holds one registered bundle.
module r_format_decode
    import cpu_pkg::*;
#(
    parameter int REG_COUNT  = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_input,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instruction,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            ALU_operation,
    output logic [4:0]            rs_address,
    output logic [4:0]            rd_address,
    output logic [4:0]            out_address,
    output logic [DATA_WIDTH-1:0] rs_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  illegal,
    input  logic                  write_enabled,
    input  logic [4:0]            wb_address,
    input  logic [DATA_WIDTH-1:0] wb_data
);

    logic [4:0]            rs_field, rt_field, rd_field;
    logic [DATA_WIDTH-1:0] rf_rs, rf_rt, rs_value, rt_value;
    logic                  accept;
    logic                  unused_shamt;
    decode_t               dec;

    assign rs_field     = instruction[25:21];
    assign rt_field     = instruction[20:16];
    assign rd_field     = instruction[15:11];
    assign unused_shamt = ^instruction[10:6];

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    register_file #(
        .REG_COUNT  (REG_COUNT),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (5)
    ) u_register_file (
        .clk          (clk),
        .reset_input  (reset_input),
        .read_addr_a  (rs_field),
        .read_data_a  (rf_rs),
        .read_addr_b  (rt_field),
        .read_data_b  (rf_rt),
        .write_enable (write_enabled),
        .write_addr   (wb_address),
        .write_data   (wb_data)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        dec      = decode_r_format(instruction[31:26], instruction[5:0]);
        rs_value = rf_rs;
        rt_value = rf_rt;
        // A write landing on this edge must win over the stale array value.
        if (write_enabled && wb_address != '0) begin
            if (wb_address == rs_field) rs_value = wb_data;
            if (wb_address == rt_field) rt_value = wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset_input) begin
        if (!reset_input) begin
            out_valid     <= 1'b0;
            illegal       <= 1'b0;
            ALU_operation <= 3'b000;
            rs_address    <= '0;
            rd_address    <= '0;
            out_address   <= '0;
            rs_data       <= '0;
            rd_data       <= '0;
        end else begin
            illegal <= 1'b0;
            if (accept) begin
                if (dec.legal) begin
                    out_valid     <= 1'b1;
                    ALU_operation <= dec.op;
                    rs_address    <= rs_field;
                    rd_address    <= rt_field;
                    out_address   <= rd_field;
                    rs_data       <= rs_value;
                    rd_data       <= rt_value;
                end else begin
                    // Rejected instruction is consumed; bundle registers keep old contents.
                    out_valid <= 1'b0;
                    illegal   <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_r_format_decode.sv
// Scoreboard bench for r_format_decode: directed scenarios then random traffic
// checked against a register-array reference model.
module tb_r_format_decode;

    logic        clk = 1'b0;
    logic        reset_input = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instruction = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  ALU_operation;
    logic [4:0]  rs_address, rd_address, out_address;
    logic [31:0] rs_data, rd_data;
    logic        illegal;
    logic        write_enabled = 1'b0;
    logic [4:0]  wb_address = '0;
    logic [31:0] wb_data = '0;

    r_format_decode dut (
        .clk           (clk),
        .reset_input   (reset_input),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instruction   (instruction),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ALU_operation (ALU_operation),
        .rs_address    (rs_address),
        .rd_address    (rd_address),
        .out_address   (out_address),
        .rs_data       (rs_data),
        .rd_data       (rd_data),
        .illegal       (illegal),
        .write_enabled (write_enabled),
        .wb_address    (wb_address),
        .wb_data       (wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ill;
        logic [2:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_regs [32];
    bit          m_valid;
    int          checks = 0;
    int          errors = 0;

    localparam logic [31:0] I_ADD = 32'h012A6820;
    localparam logic [31:0] I_SUB = 32'h000A6822;
    localparam logic [31:0] I_AND = 32'h012A6824;
    localparam logic [31:0] I_OR  = 32'h012A6825;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU operation table for legal R-format instructions; -1 marks illegal.
    function automatic int ref_op(input logic [31:0] ins);
        if (ins[31:26] != 6'h00) return -1;
        case (ins[5:0])
            6'h24: return 0;
            6'h25: return 1;
            6'h20: return 2;
            6'h22: return 6;
            6'h2A: return 7;
            default: return -1;
        endcase
    endfunction

    // Operand value as the register file will hold it right after this edge.
    function automatic logic [31:0] ref_read(input logic [4:0] a, input bit we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    task automatic model_clear();
        sb.delete();
        m_valid = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    endtask

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic step(input bit iv, input logic [31:0] ins, input bit ordy,
                        input bit we, input logic [4:0] wa, input logic [31:0] wd);
        bit   exp_ready, acc;
        int   op;
        exp_t e;
        in_valid      = iv;
        instruction   = ins;
        out_ready     = ordy;
        write_enabled = we;
        wb_address    = wa;
        wb_data       = wd;
        @(negedge clk);
        exp_ready = !m_valid || ordy;
        acc       = iv && exp_ready;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (acc) begin
            op    = ref_op(ins);
            e.ill = (op < 0);
            e.op  = (op < 0) ? 3'b000 : op[2:0];
            e.rs  = ins[25:21];
            e.rt  = ins[20:16];
            e.rd  = ins[15:11];
            e.a   = ref_read(ins[25:21], we, wa, wd);
            e.b   = ref_read(ins[20:16], we, wa, wd);
            sb.push_back(e);
            m_valid = !e.ill;
        end else if (ordy) begin
            m_valid = 0;
        end
        if (we && wa != 5'd0) m_regs[wa] = wd;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops on consumption or illegal pulse, peeks while stalled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_input) begin
                if (illegal) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL illegal_unexpected: got pulse expected none at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        check("illegal_pulse", 32'(illegal), 32'(e.ill));
                    end
                end
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL bundle_unexpected: got out_valid expected empty at %0t", $time);
                    end else begin
                        e = sb[0];
                        check("bundle_legal", 32'(out_valid), e.ill ? 32'd0 : 32'd1);
                        check("ALU_operation", 32'(ALU_operation), 32'(e.op));
                        check("rs_address", 32'(rs_address), 32'(e.rs));
                        check("rd_address", 32'(rd_address), 32'(e.rt));
                        check("out_address", 32'(out_address), 32'(e.rd));
                        check("rs_data", rs_data, e.a);
                        check("rd_data", rd_data, e.b);
                        if (out_ready) void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [5:0]  functs [5] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A};
        logic [31:0] ins;
        logic [4:0]  ra, rb, rc;
        model_clear();

        // Reset state
        #3;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_illegal", 32'(illegal), 32'd0);
        check("reset_alu_op", 32'(ALU_operation), 32'd0);
        check("reset_addrs", 32'({rs_address, rd_address, out_address}), 32'd0);
        check("reset_rs_data", rs_data, 32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_input = 1'b1;

        // Preload, then ADD $t5,$t1,$t2
        step(0, '0, 1, 1, 5'd9, 32'd5);
        step(0, '0, 1, 1, 5'd10, 32'd7);
        step(1, I_ADD, 1, 0, 5'd0, '0);
        // Bypass on rs
        step(1, I_ADD, 1, 1, 5'd9, 32'hDEAD_BEEF);
        // Zero register write ignored, SUB $t5,$zero,$t2
        step(0, '0, 1, 1, 5'd0, 32'hFFFF_FFFF);
        step(1, I_SUB, 1, 0, 5'd0, '0);
        // Illegal opcode and funct
        step(1, 32'h21290001, 1, 0, 5'd0, '0);
        step(1, 32'h012A6827, 1, 0, 5'd0, '0);
        step(0, '0, 1, 0, 5'd0, '0);
        step(0, '0, 1, 0, 5'd0, '0);
        // Backpressure: AND held while OR waits, with a write during the stall
        step(1, I_AND, 0, 0, 5'd0, '0);
        step(1, I_OR, 0, 1, 5'd9, 32'h1234_5678);
        step(1, I_OR, 0, 0, 5'd0, '0);
        step(1, I_OR, 1, 0, 5'd0, '0);
        step(0, '0, 1, 0, 5'd0, '0);

        // Reset mid-stall with a write-back pending on the reset edge
        step(1, I_ADD, 0, 0, 5'd0, '0);
        step(0, '0, 0, 0, 5'd0, '0);
        #2;
        reset_input = 1'b0;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_alu_op", 32'(ALU_operation), 32'd0);
        check("midreset_addrs", 32'({rs_address, rd_address, out_address}), 32'd0);
        check("midreset_rs_data", rs_data, 32'd0);
        check("midreset_rd_data", rd_data, 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        model_clear();
        write_enabled = 1'b1;
        wb_address    = 5'd9;
        wb_data       = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        write_enabled = 1'b0;
        reset_input   = 1'b1;
        step(1, I_ADD, 1, 0, 5'd0, '0);
        step(0, '0, 1, 0, 5'd0, '0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            ra = 5'($urandom_range(0, 31));
            rb = 5'($urandom_range(0, 31));
            rc = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0)
                ins = {6'h00, ra, rb, rc, 5'($urandom_range(0, 31)), functs[$urandom_range(0, 4)]};
            else
                ins = $urandom();
            step($urandom_range(0, 4) != 0, ins, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 2) == 0) ? ra : 5'($urandom_range(0, 31)), $urandom());
        end

        // Drain with a bounded number of cycles
        for (int n = 0; n < 20 && sb.size() != 0; n++) step(0, '0, 1, 0, 5'd0, '0);
        check("drain_queue_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
